// File: rtl/amx_pkg.sv
// amx_pkg: shared types and constants for the amx byte-stream framer.
//   AMX_SYNC_BYTE   default frame start marker
//   amx_byte_t      one stream byte
//   amx_rx_state_t  receive FSM state encoding
//   amx_len_legal   payload length legality helper
package amx_pkg;

    localparam logic [7:0] AMX_SYNC_BYTE = 8'hA5;

    typedef logic [7:0] amx_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DROP    = 3'd4
    } amx_rx_state_t;

    // A length is legal when it is non-zero and not above the configured maximum.
    function automatic logic amx_len_legal(input amx_byte_t len, input int max_len);
        return (len != 8'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/amx_spec_fifo.sv
// amx_spec_fifo: FIFO with a speculative write pointer.
// Bytes are written at the speculative pointer; they become visible to the
// reader only when `commit` copies the speculative pointer into the commit
// pointer. `rollback` discards uncommitted bytes.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   spec_start      restart speculation at the commit pointer
//   wr_en, wr_data  speculative write
//   commit          publish speculative bytes
//   rollback        discard speculative bytes
//   rd_en           pop head when rd_valid
//   rd_data         FWFT head byte (0 when empty)
//   rd_valid        committed data available
//   free_cnt        DEPTH minus committed occupancy
module amx_spec_fifo
    import amx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spec_start,
    input  logic                     wr_en,
    input  amx_byte_t                wr_data,
    input  logic                     commit,
    input  logic                     rollback,
    input  logic                     rd_en,
    output amx_byte_t                rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] cm_ptr_q, cm_ptr_d;
    logic [AW:0] sp_ptr_q, sp_ptr_d;
    amx_byte_t   mem_q [DEPTH];

    // Pointers carry one extra wrap bit, so plain subtraction gives occupancy.
    assign rd_valid = (cm_ptr_q != rd_ptr_q);
    assign free_cnt = DEPTH_W - (cm_ptr_q - rd_ptr_q);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;

    // Next-state pointer arithmetic.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        cm_ptr_d = cm_ptr_q;
        sp_ptr_d = sp_ptr_q;
        if (rd_en && rd_valid) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (spec_start || rollback) begin
            sp_ptr_d = cm_ptr_q;
        end else if (wr_en) begin
            sp_ptr_d = sp_ptr_q + PTR_ONE;
        end else begin
            sp_ptr_d = sp_ptr_q;
        end
        if (commit) begin
            cm_ptr_d = sp_ptr_q;
        end else begin
            cm_ptr_d = cm_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            cm_ptr_q <= '0;
            sp_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            sp_ptr_q <= sp_ptr_d;
        end
    end

    // Storage array; contents need no reset because reads are masked when empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[sp_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/amx_frame_rx.sv
// amx_frame_rx: finds SYNC/LEN/payload/CHK frames in a strobed byte stream,
// verifies the XOR checksum and commits good payloads to a speculative FIFO.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_byte, in_stb       input byte stream, one byte per strobed cycle
//   out_data, out_valid   FWFT committed data
//   out_ready             consumer pop
//   frame_good/bad/drop   one-cycle outcome pulses
//   busy                  receiver is inside a frame
module amx_frame_rx
    import amx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = AMX_SYNC_BYTE,
    parameter int         MAX_LEN   = 8,
    parameter int         DEPTH     = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  amx_byte_t in_byte,
    input  logic      in_stb,
    output amx_byte_t out_data,
    output logic      out_valid,
    input  logic      out_ready,
    output logic      frame_good,
    output logic      frame_bad,
    output logic      frame_drop,
    output logic      busy
);

    localparam int AW = $clog2(DEPTH);

    amx_rx_state_t state_q, state_d;
    amx_byte_t     cnt_q, cnt_d;
    amx_byte_t     acc_q, acc_d;
    logic          good_q, good_d;
    logic          bad_q, bad_d;
    logic          drop_q, drop_d;
    logic          busy_q;

    logic          spec_start_s;
    logic          wr_en_s;
    logic          commit_s;
    logic          rollback_s;
    logic [AW:0]   free_cnt_s;

    amx_spec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .spec_start (spec_start_s),
        .wr_en      (wr_en_s),
        .wr_data    (in_byte),
        .commit     (commit_s),
        .rollback   (rollback_s),
        .rd_en      (out_ready),
        .rd_data    (out_data),
        .rd_valid   (out_valid),
        .free_cnt   (free_cnt_s)
    );

    // Frame parser: every transition is gated by in_stb, so gaps simply hold.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        good_d       = 1'b0;
        bad_d        = 1'b0;
        drop_d       = 1'b0;
        spec_start_s = 1'b0;
        wr_en_s      = 1'b0;
        commit_s     = 1'b0;
        rollback_s   = 1'b0;
        if (in_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_byte == SYNC_BYTE) begin
                        state_d = ST_LEN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LEN: begin
                    if (!amx_len_legal(in_byte, MAX_LEN)) begin
                        bad_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (int'(free_cnt_s) < int'(in_byte)) begin
                        // Skip payload plus checksum byte.
                        cnt_d   = in_byte + 8'd1;
                        state_d = ST_DROP;
                    end else begin
                        acc_d        = in_byte;
                        cnt_d        = in_byte;
                        spec_start_s = 1'b1;
                        state_d      = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    wr_en_s = 1'b1;
                    acc_d   = acc_q ^ in_byte;
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_CHK: begin
                    if ((acc_q ^ in_byte) == 8'd0) begin
                        commit_s = 1'b1;
                        good_d   = 1'b1;
                    end else begin
                        rollback_s = 1'b1;
                        bad_d      = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                ST_DROP: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        drop_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM state, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            acc_q   <= 8'd0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            drop_q  <= drop_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign frame_good = good_q;
    assign frame_bad  = bad_q;
    assign frame_drop = drop_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_amx_frame_rx.sv
// tb_amx_frame_rx: directed test-plan scenarios followed by randomized frame
// traffic, every cycle compared against a queue-based reference model.
module tb_amx_frame_rx;

    localparam int         DEPTH   = 16;
    localparam int         MAX_LEN = 8;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_stb = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       frame_good, frame_bad, frame_drop, busy;

    amx_frame_rx #(.SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_byte    (in_byte),
        .in_stb     (in_stb),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_good (frame_good),
        .frame_bad  (frame_bad),
        .frame_drop (frame_drop),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 1;      // 0: never ready, 1: always ready, 2: random
    int drop_seen = 0;

    // Reference model: committed bytes, bytes of the frame in progress.
    logic [7:0] mq[$];
    logic [7:0] fb[$];
    bit m_in, m_skip, m_good, m_bad, m_drop;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        fb.delete();
        m_in = 0; m_skip = 0; m_good = 0; m_bad = 0; m_drop = 0;
    endtask

    // One clock edge of the reference: parse the byte, then pop, then commit.
    task automatic model_step(input logic [7:0] b, input bit stb, input bit rdy);
        bit pop;
        logic [7:0] x;
        logic [7:0] commit_bytes[$];
        m_good = 0; m_bad = 0; m_drop = 0;
        pop = rdy && (mq.size() > 0);
        if (stb) begin
            if (!m_in) begin
                if (b == SYNC) begin
                    m_in = 1; m_skip = 0; fb.delete();
                end
            end else begin
                fb.push_back(b);
                if (fb.size() == 1) begin
                    if (b == 8'd0 || int'(b) > MAX_LEN) begin
                        m_bad = 1; m_in = 0;
                    end else if (DEPTH - mq.size() < int'(b)) begin
                        m_skip = 1;
                    end
                end else if (fb.size() == int'(fb[0]) + 2) begin
                    m_in = 0;
                    if (m_skip) begin
                        m_drop = 1;
                    end else begin
                        x = 8'h00;
                        foreach (fb[i]) x = x ^ fb[i];
                        if (x == 8'h00) begin
                            m_good = 1;
                            for (int i = 1; i <= int'(fb[0]); i++) commit_bytes.push_back(fb[i]);
                        end else begin
                            m_bad = 1;
                        end
                    end
                end
            end
        end
        if (pop) void'(mq.pop_front());
        foreach (commit_bytes[i]) mq.push_back(commit_bytes[i]);
    endtask

    task automatic compare_outputs(input string where);
        check_val({where, ":out_valid"}, out_valid, (mq.size() > 0));
        check_val({where, ":out_data"}, out_data, (mq.size() > 0) ? int'(mq[0]) : 0);
        check_val({where, ":frame_good"}, frame_good, m_good);
        check_val({where, ":frame_bad"}, frame_bad, m_bad);
        check_val({where, ":frame_drop"}, frame_drop, m_drop);
        check_val({where, ":busy"}, busy, m_in);
    endtask

    task automatic cycle(input logic [7:0] b, input bit stb);
        bit rdy;
        case (rdy_mode)
            0: rdy = 0;
            1: rdy = 1;
            default: rdy = bit'($urandom_range(0, 1));
        endcase
        in_byte = b; in_stb = stb; out_ready = rdy;
        @(posedge clk);
        model_step(b, stb, rdy);
        if (m_drop) drop_seen++;
        #1;
        compare_outputs("cyc");
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        cycle(b, 1'b1);
        repeat (gap) cycle(8'($urandom), 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(8'($urandom), 1'b0);
    endtask

    // kind 0: good checksum, 1: corrupted checksum.
    task automatic send_frame(input int len, input int kind, input int gap);
        logic [7:0] x;
        logic [7:0] p;
        x = 8'(len);
        send_byte(SYNC, gap);
        send_byte(8'(len), gap);
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom);
            x = x ^ p;
            send_byte(p, gap);
        end
        if (kind == 1) x = x ^ 8'(1 + $urandom_range(0, 254));
        send_byte(x, gap);
    endtask

    task automatic do_reset();
        in_stb = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Good frame, drained immediately.
        rdy_mode = 1;
        send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
        send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h03, 0);
        idle(5);

        // Bad checksum.
        send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
        send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h04, 0);
        idle(3);

        // Bad lengths, then a one-byte frame.
        send_byte(8'hA5, 0); send_byte(8'h00, 0);
        send_byte(8'hA5, 0); send_byte(8'h09, 0);
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h7E, 0); send_byte(8'h7F, 0);
        idle(4);

        // Fill all 16 entries, then a frame that cannot fit.
        rdy_mode = 0;
        send_frame(8, 0, 0);
        send_frame(8, 0, 0);
        drop_seen = 0;
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h55, 0); send_byte(8'h54, 0);
        check_val("drop_pulse_count", drop_seen, 1);
        check_val("full_occupancy", mq.size(), 16);
        rdy_mode = 1;
        idle(20);

        // Garbage, embedded sync bytes and 3-cycle strobe gaps.
        send_byte(8'h00, 3); send_byte(8'hFF, 3);
        send_byte(8'hA5, 3); send_byte(8'h02, 3); send_byte(8'hA5, 3);
        send_byte(8'hA5, 3); send_byte(8'h02, 3);
        idle(4);

        // Reset in the middle of a payload with committed data pending.
        rdy_mode = 0;
        send_frame(4, 0, 0);
        send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        do_reset();
        rdy_mode = 1;
        send_frame(5, 0, 0);
        idle(8);

        // Randomized traffic.
        rdy_mode = 2;
        for (int n = 0; n < 120; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                send_frame($urandom_range(1, MAX_LEN), 0, $urandom_range(0, 2));
            end else if (sel <= 6) begin
                send_frame($urandom_range(1, MAX_LEN), 1, $urandom_range(0, 1));
            end else if (sel == 7) begin
                send_byte(SYNC, $urandom_range(0, 1));
                send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)), 0);
            end else if (sel == 8) begin
                send_byte(8'($urandom), $urandom_range(0, 2));
            end else begin
                idle($urandom_range(1, 6));
            end
        end

        rdy_mode = 1;
        idle(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/amx_frame_rx.md
# amx_frame_rx

Byte-stream framer in front of `amx_core1`; accepts raw bytes from the pad inputs, finds framed packets, and checks each packet's XOR checksum. Each payload byte goes into a speculative FIFO, and a packet's bytes are committed only when its checksum passes. `amx_core1` drains the committed bytes through a valid/ready handshake. Bad, malformed or unfittable frames never reach the core.

## Interface
- `SYNC_BYTE`, 8'hA5: frame start marker
- `MAX_LEN`, 8: largest legal payload length (1..DEPTH)
- `DEPTH`, 16: FIFO entries, power of two
- `clk` in 1: single clock; all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_byte` in 8: incoming byte, sampled when `in_stb`=1
- `in_stb` in 1: one byte per cycle when high; no backpressure
- `out_data` out 8: head-of-FIFO byte (first-word-fall-through)
- `out_valid` out 1: committed data available
- `out_ready` in 1: consumer pops head when `out_valid`&`out_ready`
- `frame_good` out 1: 1-cycle pulse, frame committed
- `frame_bad` out 1: 1-cycle pulse, bad length or checksum
- `frame_drop` out 1: 1-cycle pulse, frame skipped for lack of space
- `busy` out 1: FSM not in IDLE

## Operation
- **Frame format:** `SYNC_BYTE`, `LEN`, `LEN` payload bytes, `CHK`.
  - Valid when XOR(`LEN`, payload, `CHK`) == 0.
- **FSM states:** IDLE, LEN, PAYLOAD, CHK, DROP. All transitions occur only on bytes where `in_stb`=1. When `in_stb`=0 the FSM holds; there is no timeout.
- **IDLE:**
  - Bytes other than `SYNC_BYTE` are discarded.
  - `SYNC_BYTE` moves to LEN.
- **LEN:**
  - `LEN`==0 or `LEN`>`MAX_LEN`: `frame_bad` pulse, go to IDLE.
  - Otherwise, if free space (DEPTH − committed count) < `LEN`: latch a skip count of `LEN`+1 and go to DROP.
  - Otherwise: seed the XOR accumulator with `LEN`, reset the speculative write pointer to the commit pointer, and go to PAYLOAD.
- **PAYLOAD:**
  - Each byte is written at the speculative pointer, which then increments; the byte is XORed into the accumulator.
  - After `LEN` bytes, go to CHK.
  - A `SYNC_BYTE` value inside the payload is ordinary data.
- **CHK:**
  - Accumulator ^ `CHK` == 0: commit pointer ← speculative pointer, `frame_good` pulse.
  - Otherwise: speculative pointer ← commit pointer (rollback), `frame_bad` pulse.
  - Both outcomes go to IDLE.
- **DROP:** discards `LEN`+1 bytes (payload and `CHK`), then pulses `frame_drop` and goes to IDLE.
- **Read side:**
  - `out_valid` = (commit pointer ≠ read pointer).
  - Pops occur independently of the FSM.
  - Space is checked only at LEN. Reads during a frame only increase space, so an accepted frame can never overflow.
- **Pointers:** log2(DEPTH)+1 bits wide, with wrap-around. Full when the MSBs differ and the remaining bits are equal.

## Timing
- **Reset (async assert, sync-style deassert handled at top):**
  - FSM = IDLE; all pointers = 0.
  - `out_valid`, `frame_good`, `frame_bad`, `frame_drop`, `busy` = 0; `out_data` = 0 while empty.
- **Reset mid-frame:** the partial frame is lost and the FIFO is emptied, including committed data.
- **Commit latency:** the `CHK` byte is sampled at edge k. Both `frame_good` and `out_valid` are high in the cycle after edge k.
  - Minimum input-to-output latency is `LEN`+3 strobed bytes + 1 cycle.
- **Pop:** when `out_valid`&`out_ready` at edge k, `out_data` shows the next entry after edge k.
- **Simultaneous commit and pop at the same edge:** both take effect. The count = old + `LEN` − 1.
- **Pulse timing:** `frame_bad` and `frame_drop` are high for exactly the cycle after the deciding byte's edge.
- **Back-to-back frames:** a `SYNC_BYTE` immediately after `CHK` is accepted, with no idle gap.

## Structure
- **Package `amx_pkg`:** `SYNC_BYTE` default, FSM state enum `amx_rx_state_t`, byte typedef.
- **Sub-module `amx_spec_fifo`:**
  - Contents: DEPTH×8 memory, read/commit/speculative pointers, `wr_en`, `commit`, `rollback`, `free_cnt`, FWFT read port.
  - Division of work: `amx_frame_rx` holds the FSM, length counter and XOR accumulator.
- **Top-level wiring:** `ui_in` → `in_byte`, `uio_in[0]` → `in_stb`, `out_data` → `amx_core1.data_in`, `out_ready` tied high or driven from core.

## Test plan
- **Good frame:** A5 03 11 22 33 03 with `out_ready`=1 → `frame_good` pulse; `out_data` sequence 11, 22, 33, then `out_valid`=0.
- **Bad checksum:** A5 03 11 22 33 04 → `frame_bad` pulse; `out_valid` stays 0 and the pointers are unchanged.
- **Bad length:** A5 00, and A5 09 (`MAX_LEN`=8) → `frame_bad` after the length byte; a following A5 01 7E 7F yields a single output 7E.
- **Full FIFO:** with `out_ready`=0, send two valid 8-byte frames (16 entries), then A5 01 55 54 → `frame_drop`, and the FIFO still holds 16 entries. Raise `out_ready` → exactly 16 bytes out, in order.
- **Garbage, embedded sync, gaps:** garbage 00 FF before A5 02 A5 A5 02, with `in_stb` gaps of 3 cycles between bytes → output A5, A5; `busy` stays high through the gaps.
- **Reset mid-frame:** assert `rst_n`=0 mid-payload after a committed frame → `out_valid`=0 immediately. The next valid frame after reset is received correctly.
